// File: rtl/nanop_pkg.sv
// Opcode map, FSM state encoding and decode helpers for the nanoprocessor sequencer.
// The HALT state exists only when NANOP_HALT_EN is defined.
package nanop_pkg;

    localparam logic [7:0] NOP = 8'h00;
    localparam logic [7:0] XOR = 8'h01;
    localparam logic [7:0] AND = 8'h02;
    localparam logic [7:0] OR  = 8'h03;
    localparam logic [7:0] ADD = 8'h04;
    localparam logic [7:0] ADC = 8'h05;
    localparam logic [7:0] SUB = 8'h06;
    localparam logic [7:0] SBC = 8'h07;
    localparam logic [7:0] ROL = 8'h08;
    localparam logic [7:0] ROR = 8'h09;
    localparam logic [7:0] LDA = 8'h0A;
    localparam logic [7:0] STA = 8'h0B;
    localparam logic [7:0] OUT = 8'h0C;
    localparam logic [7:0] JMP = 8'h0D;
    localparam logic [7:0] JNC = 8'h0E;
    localparam logic [7:0] JNZ = 8'h0F;
    localparam logic [7:0] HLT = 8'hFF;

`ifdef NANOP_HALT_EN
    typedef enum logic [1:0] {
        IF   = 2'd0,
        AF   = 2'd1,
        EX   = 2'd2,
        HALT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IF = 2'd0,
        AF = 2'd1,
        EX = 2'd2
    } state_t;
`endif

    function automatic logic is_alu_op(input logic [7:0] op);
        case (op)
            XOR, AND, OR, ADD, ADC, SUB, SBC, ROL, ROR: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            LDA, STA, OUT: return 1'b1;
            default:       return is_alu_op(op);
        endcase
    endfunction

    function automatic logic writes_carry(input logic [7:0] op);
        case (op)
            ADD, SUB, ADC, SBC, ROL, ROR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nanop_pc.sv
// AW-wide program counter with increment and parallel load; load wins over increment.
module nanop_pc #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/nanop_seq.sv
// Nanoprocessor sequencer: IF/AF/EX FSM, PC, flags and datapath strobe decode with memory wait.
// Optional HLT instruction enabled by defining NANOP_HALT_EN.
module nanop_seq
    import nanop_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] I,
    input  logic [AW-1:0] addr,
    input  logic          mem_ready,
    input  logic          alu_c,
    input  logic          alu_z,
    output logic [AW-1:0] PC,
    output logic          Load_I,
    output logic          Load_Acc,
    output logic          Sel_Acc,
    output logic          Load_Addr,
    output logic          Sel_Addr,
    output logic          WRITE,
    output logic          Load_Out,
    output logic          C,
    output logic          Z,
    output logic          halted
);

    state_t     state_q;
    logic       c_q;
    logic       z_q;
    logic [7:0] op;
    logic       mem_op;
    logic       ex_done;
    logic       pc_inc;
    logic       pc_load;

    // Opcodes with any bit set above the 8-bit map are unknown and run as NOP.
    always_comb begin
        op      = ((I >> 8) == '0) ? I[7:0] : NOP;
        mem_op  = is_mem_op(op);
        ex_done = (state_q == EX) && (!mem_op || mem_ready);
        pc_inc  = ((state_q == IF) || (state_q == AF)) && mem_ready;
        pc_load = ex_done && ((op == JMP) ||
                              ((op == JNC) && !c_q) ||
                              ((op == JNZ) && !z_q));
    end

    always_comb begin
        Load_I    = 1'b0;
        Load_Acc  = 1'b0;
        Sel_Acc   = 1'b0;
        Load_Addr = 1'b0;
        Sel_Addr  = 1'b0;
        WRITE     = 1'b0;
        Load_Out  = 1'b0;
        case (state_q)
            IF: Load_I    = mem_ready;
            AF: Load_Addr = mem_ready;
            EX: begin
                if (mem_op) begin
                    Sel_Addr = mem_ready;
                    // The store strobe is held for the whole wait, unlike the load strobes.
                    WRITE    = (op == STA);
                    Load_Acc = mem_ready && ((op == LDA) || is_alu_op(op));
                    Sel_Acc  = mem_ready && (op == LDA);
                    Load_Out = mem_ready && (op == OUT);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IF;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            case (state_q)
                IF: if (mem_ready) state_q <= AF;
                AF: if (mem_ready) state_q <= EX;
                EX: begin
                    if (ex_done) begin
                        if (Load_Acc) z_q <= alu_z;
                        if (writes_carry(op)) c_q <= alu_c;
`ifdef NANOP_HALT_EN
                        state_q <= (op == HLT) ? HALT : IF;
`else
                        state_q <= IF;
`endif
                    end
                end
`ifdef NANOP_HALT_EN
                HALT: state_q <= HALT;
`endif
                default: state_q <= IF;
            endcase
        end
    end

    nanop_pc #(.AW(AW)) u_pc (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (addr),
        .pc_o       (PC)
    );

    assign C = c_q;
    assign Z = z_q;

`ifdef NANOP_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
